dmem_access_initiator: RTL and testbench

- CPU-side initiator for the data-memory port of the dual-ported memory; it drives the dmem request channel and consumes the dmem response channel.
- Accepts load/store commands from the pipeline with byte/half/word size and signedness.
- Memory traffic is word-aligned only. Loads are extracted and extended locally; sub-word stores are done as read-modify-write.
- Flags misalignment faults and response timeouts to the pipeline.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_lane_align.sv | 24 ++
 rtl/dmem_access_initiator.sv | 107 ++++++++++
 tb/tb_dmem_access_initiator.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared memory-op codes, access sizes and initiator FSM states.
package dmem_pkg;
   localparam logic [1:0] MEM_READ      = 2'd0;
   localparam logic [1:0] MEM_WRITE     = 2'd1;
   localparam logic [1:0] MEM_READWRITE = 2'd2;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;
   typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
   function automatic logic misaligned(input logic [1:0] a, input logic [1:0] s);
      return s == SZ_RSVD || (s == SZ_HALF && a[0]) || (s == SZ_WORD && a != 2'b00);
   endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [4:0]  sh;
   logic [31:0] mask;
   assign byte_v     = word[{lane, 3'b000} +: 8];
   assign half_v     = lane[1] ? word[31:16] : word[15:0];
   assign load_data  = size == SZ_BYTE ? {{24{sext & byte_v[7]}}, byte_v}
                     : size == SZ_HALF ? {{16{sext & half_v[15]}}, half_v} : word;
   assign sh         = size == SZ_HALF ? {lane[1], 4'b0000} : {lane, 3'b000};
   assign mask       = (size == SZ_HALF ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
   assign store_word = size == SZ_WORD ? wdata : (word & ~mask) | ((wdata << sh) & mask);
endmodule

// File: rtl/dmem_access_initiator.sv
// dmem_access_initiator: pipeline load/store front end driving a word-aligned dmem port,
// with local lane extract/extend, read-modify-write sub-word stores, fault and timeout reporting.
module dmem_access_initiator
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pipe_valid,
   output logic        pipe_ready,
   input  logic [31:0] pipe_addr,
   input  logic [31:0] pipe_wdata,
   input  logic        pipe_write,
   input  logic [1:0]  pipe_size,
   input  logic        pipe_sext,
   output logic        pipe_done,
   output logic [31:0] pipe_rdata,
   output logic        pipe_fault,
   output logic        pipe_error,
   output logic        io_dmem_request_valid,
   output logic [31:0] io_dmem_request_bits_address,
   output logic [31:0] io_dmem_request_bits_writedata,
   output logic [1:0]  io_dmem_request_bits_operation,
   input  logic        io_dmem_response_valid,
   input  logic [31:0] io_dmem_response_bits_data
);
   localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   state_t        state;
   logic [31:0]   addr_q, wdata_q, wr_data;
   logic [1:0]    size_q;
   logic          write_q, sext_q;
   logic [CW-1:0] cnt;
   logic [31:0]   load_val, merged;
   dmem_lane_align u_align (
      .word       (io_dmem_response_bits_data),
      .lane       (addr_q[1:0]),
      .size       (size_q),
      .sext       (sext_q),
      .wdata      (wdata_q),
      .load_data  (load_val),
      .store_word (merged)
   );
   assign pipe_ready                     = state == IDLE;
   assign pipe_done                      = state == FIN;
   assign io_dmem_request_valid          = state == RD || state == WR;
   assign io_dmem_request_bits_operation = state == WR ? MEM_WRITE : MEM_READ;
   assign io_dmem_request_bits_address   = {addr_q[31:2], 2'b00};
   assign io_dmem_request_bits_writedata = wr_data;
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wr_data    <= '0;
         size_q     <= SZ_BYTE;
         write_q    <= 1'b0;
         sext_q     <= 1'b0;
         cnt        <= '0;
         pipe_rdata <= '0;
         pipe_fault <= 1'b0;
         pipe_error <= 1'b0;
      end else begin
         case (state)
            IDLE: if (pipe_valid) begin
               addr_q     <= pipe_addr;
               wdata_q    <= pipe_wdata;
               size_q     <= pipe_size;
               write_q    <= pipe_write;
               sext_q     <= pipe_sext;
               cnt        <= '0;
               pipe_rdata <= '0;
               if (misaligned(pipe_addr[1:0], pipe_size)) begin
                  pipe_fault <= 1'b1;
                  state      <= FIN;
               end else if (pipe_write && pipe_size == SZ_WORD) begin
                  wr_data <= pipe_wdata;
                  state   <= WR;
               end else
                  state <= RD;
            end
            RD: begin
               cnt <= cnt + 1'b1;
               if (io_dmem_response_valid) begin
                  if (write_q) begin
                     wr_data <= merged;
                     state   <= WR;
                  end else begin
                     pipe_rdata <= load_val;
                     state      <= FIN;
                  end
               end else if (TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  pipe_error <= 1'b1;
                  pipe_rdata <= '0;
                  state      <= FIN;
               end
            end
            WR: state <= FIN;
            FIN: begin
               pipe_fault <= 1'b0;
               pipe_error <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_access_initiator.sv
// tb_dmem_access_initiator: random load/store traffic against a byte-array memory model.
module tb_dmem_access_initiator;
   localparam int TMO = 4;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        pipe_valid = 1'b0, pipe_write = 1'b0, pipe_sext = 1'b0;
   logic [31:0] pipe_addr = '0, pipe_wdata = '0;
   logic [1:0]  pipe_size = '0;
   logic        pipe_ready, pipe_done, pipe_fault, pipe_error;
   logic [31:0] pipe_rdata;
   logic        req_valid, resp_valid;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_op;
   logic [31:0] mem [0:255];
   logic [7:0]  refb [0:1023];
   logic        poke = 1'b0;
   logic [7:0]  poke_idx = '0;
   logic [31:0] poke_val = '0;
   int          wait_n = 0, rd_cnt = 0, req_cycles = 0, wr_count = 0;
   int          n_cmp = 0, n_bad = 0;
   dmem_access_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock                          (clock),
      .reset                          (reset),
      .pipe_valid                     (pipe_valid),
      .pipe_ready                     (pipe_ready),
      .pipe_addr                      (pipe_addr),
      .pipe_wdata                     (pipe_wdata),
      .pipe_write                     (pipe_write),
      .pipe_size                      (pipe_size),
      .pipe_sext                      (pipe_sext),
      .pipe_done                      (pipe_done),
      .pipe_rdata                     (pipe_rdata),
      .pipe_fault                     (pipe_fault),
      .pipe_error                     (pipe_error),
      .io_dmem_request_valid          (req_valid),
      .io_dmem_request_bits_address   (req_addr),
      .io_dmem_request_bits_writedata (req_wdata),
      .io_dmem_request_bits_operation (req_op),
      .io_dmem_response_valid         (resp_valid),
      .io_dmem_response_bits_data     (mem[req_addr[9:2]])
   );
   always #5 clock = ~clock;
   // Combinational memory that withholds its read response for wait_n cycles.
   assign resp_valid = req_valid && req_op == 2'd0 && rd_cnt >= wait_n;
   always @(posedge clock) begin
      rd_cnt     <= (req_valid && req_op == 2'd0 && !resp_valid) ? rd_cnt + 1 : 0;
      req_cycles <= req_cycles + int'(req_valid);
      if (req_valid && req_op == 2'd1) begin
         wr_count          <= wr_count + 1;
         mem[req_addr[9:2]] <= req_wdata;
      end
      if (poke) mem[poke_idx] <= poke_val;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] ref_word(input int idx);
      return {refb[4*idx+3], refb[4*idx+2], refb[4*idx+1], refb[4*idx]};
   endfunction
   task automatic poke_word(input int idx, input logic [31:0] v);
      @(negedge clock);
      poke = 1'b1; poke_idx = 8'(idx); poke_val = v;
      for (int i = 0; i < 4; i++) refb[4*idx+i] = v[8*i +: 8];
      @(negedge clock);
      poke = 1'b0;
   endtask
   task automatic cmd(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                      input logic [1:0] sz, input logic sx, input int wt);
      int n, lat, rq0, wr0, exp_lat, exp_rq;
      logic flt, to;
      logic [31:0] v;
      n   = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      flt = sz == 2'd3 || (a % n) != 0;
      to  = !flt && !(wr && sz == 2'd2) && wt >= TMO;
      v   = 0;
      for (int i = 0; i < n; i++) v = v | (32'(refb[a[9:0] + i]) << (8 * i));
      if (sx && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
      if (flt) begin exp_lat = 1; exp_rq = 0; end
      else if (wr && sz == 2'd2) begin exp_lat = 2; exp_rq = 1; end
      else if (to) begin exp_lat = 1 + TMO; exp_rq = TMO; end
      else begin exp_lat = 2 + wt + int'(wr); exp_rq = wt + 1 + int'(wr); end
      wait_n = wt;
      @(negedge clock);
      chk("ready", 32'(pipe_ready), 1);
      rq0 = req_cycles; wr0 = wr_count;
      pipe_valid = 1'b1; pipe_addr = a; pipe_wdata = wd; pipe_write = wr; pipe_size = sz; pipe_sext = sx;
      @(negedge clock);
      pipe_valid = 1'b0;
      lat = 1;
      while (!pipe_done && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("fault", 32'(pipe_fault), 32'(flt));
      chk("error", 32'(pipe_error), 32'(to));
      if (!flt && (!wr || to)) chk("rdata", pipe_rdata, to ? 0 : v);
      chk("req_cycles", req_cycles - rq0, exp_rq);
      chk("writes", wr_count - wr0, (wr && !flt && !to) ? 1 : 0);
      if (wr && !flt && !to)
         for (int i = 0; i < n; i++) refb[a[9:0] + i] = wd[8*i +: 8];
      chk("mem_word", mem[a[9:2]], ref_word(int'(a[9:2])));
   endtask
   initial begin
      int rq0, wr0;
      repeat (2) @(negedge clock);
      chk("rst_ready", 32'(pipe_ready), 1);
      chk("rst_done", 32'(pipe_done), 0);
      chk("rst_req", 32'(req_valid), 0);
      chk("rst_rdata", pipe_rdata, 0);
      chk("rst_flags", {pipe_fault, pipe_error}, 0);
      chk("rst_addr", req_addr, 0);
      reset = 1'b0;
      for (int i = 0; i < 256; i++) poke_word(i, $urandom);
      poke_word(32'h100 >> 2, 32'hDEADBEEF);
      cmd(32'h100, 0, 1'b0, 2'd2, 1'b0, 0);
      chk("word_load", pipe_rdata, 32'hDEADBEEF);
      cmd(32'h103, 0, 1'b0, 2'd0, 1'b1, 0);
      chk("sbyte_load", pipe_rdata, 32'hFFFFFFDE);
      cmd(32'h103, 0, 1'b0, 2'd0, 1'b0, 0);
      chk("ubyte_load", pipe_rdata, 32'h000000DE);
      poke_word(32'h100 >> 2, 32'h11223344);
      cmd(32'h102, 32'h0000ABCD, 1'b1, 2'd1, 1'b0, 0);
      chk("half_store", mem[32'h100 >> 2], 32'hABCD3344);
      cmd(32'h101, 0, 1'b0, 2'd1, 1'b0, 0);
      cmd(32'h100, 0, 1'b0, 2'd2, 1'b0, 100);
      cmd(32'h100, 0, 1'b0, 2'd2, 1'b0, 1);
      chk("after_timeout", pipe_rdata, 32'hABCD3344);
      // Reset in the middle of a byte store's read phase must suppress the write.
      wait_n = 100;
      rq0 = req_cycles; wr0 = wr_count;
      @(negedge clock);
      pipe_valid = 1'b1; pipe_addr = 32'h205; pipe_wdata = 32'h5A; pipe_write = 1'b1; pipe_size = 2'd0;
      @(negedge clock);
      pipe_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("rmw_rst_ready", 32'(pipe_ready), 1);
      chk("rmw_rst_req", 32'(req_valid), 0);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("rmw_rst_writes", wr_count - wr0, 0);
      chk("rmw_rst_reads", req_cycles - rq0, 2);
      chk("rmw_rst_mem", mem[32'h205 >> 2], ref_word(32'h205 >> 2));
      for (int k = 0; k < 300; k++)
         cmd($urandom_range(0, 1023), $urandom, 1'($urandom), 2'($urandom), 1'($urandom),
             $urandom_range(0, 9) == 0 ? TMO + int'($urandom_range(0, 2)) : $urandom_range(0, TMO - 1));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
